fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns the PC, issues instruction-memory reads,

---
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, reads imem, buffers words in a 2-entry queue and drives IF/ID.
// Latency 1 clk (zero-wait imem); ID stall fills the queue, then imem_req drops.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 'h1,
    parameter int                PC_STEP  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ready,
    input  logic [DATA_W-1:0] i_imem_rdata,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic [DATA_W-1:0] o_if_id_instr,
    output logic [ADDR_W-1:0] o_if_id_pc4,
    output logic              o_if_id_valid
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_q_instr [0:1];
    logic [ADDR_W-1:0] r_q_pc4   [0:1];
    logic [DATA_W-1:0] r_if_id_instr;
    logic [ADDR_W-1:0] r_if_id_pc4;
    logic              r_if_id_valid;

    logic              w_req;
    logic              w_fire;
    logic              w_pop;
    logic              w_bypass;
    logic              w_push;
    logic              w_wr_idx;
    logic [ADDR_W-1:0] w_pc4;

    always_comb begin
        w_req    = ((r_state == S_FETCH) && (r_count != 2'd2)) || (r_state == S_WAIT);
        w_fire   = w_req && i_imem_ready && !i_branch_taken;
        w_pop    = !i_branch_taken && !i_stall && (r_count != 2'd0);
        // Empty queue and ID accepting: the returning word skips the queue entirely.
        w_bypass = !i_branch_taken && !i_stall && (r_count == 2'd0) && w_fire;
        w_push   = w_fire && !w_bypass;
        w_wr_idx = w_pop ? (r_count == 2'd2) : (r_count == 2'd1);
        w_pc4    = r_pc + STEP;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_FETCH;
            S_FETCH: if (w_req && !i_imem_ready) w_state_nxt = S_WAIT;
            S_WAIT:  if (i_imem_ready) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_BOOT;
        endcase
        if (i_branch_taken) w_state_nxt = S_FETCH;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (i_branch_taken)
                r_pc <= i_branch_target;
            else if (w_fire)
                r_pc <= w_pc4;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count      <= 2'd0;
            r_q_instr[0] <= '0;
            r_q_instr[1] <= '0;
            r_q_pc4[0]   <= '0;
            r_q_pc4[1]   <= '0;
        end else if (i_branch_taken) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_q_instr[0] <= r_q_instr[1];
                r_q_pc4[0]   <= r_q_pc4[1];
            end
            // Later write wins over the shift when the slot coincides.
            if (w_push) begin
                r_q_instr[w_wr_idx] <= i_imem_rdata;
                r_q_pc4[w_wr_idx]   <= w_pc4;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_id_instr <= '0;
            r_if_id_pc4   <= '0;
            r_if_id_valid <= 1'b0;
        end else if (i_branch_taken) begin
            r_if_id_instr <= '0;
            r_if_id_valid <= 1'b0;
        end else if (i_stall) begin
            r_if_id_valid <= r_if_id_valid;
        end else if (w_pop) begin
            r_if_id_instr <= r_q_instr[0];
            r_if_id_pc4   <= r_q_pc4[0];
            r_if_id_valid <= 1'b1;
        end else if (w_bypass) begin
            r_if_id_instr <= i_imem_rdata;
            r_if_id_pc4   <= w_pc4;
            r_if_id_valid <= 1'b1;
        end else begin
            r_if_id_instr <= '0;
            r_if_id_valid <= 1'b0;
        end
    end

    assign o_imem_req    = w_req;
    assign o_imem_addr   = r_pc;
    assign o_if_id_instr = r_if_id_instr;
    assign o_if_id_pc4   = r_if_id_pc4;
    assign o_if_id_valid = r_if_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table for streaming/stall, hand sequences for corner cases,
// scoreboard of fetched words checked against IF/ID in order.
module tb_fetch_stage;
    logic        i_clk;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic [31:0] o_if_id_instr;
    logic [31:0] o_if_id_pc4;
    logic        o_if_id_valid;

    fetch_stage dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_ready    (i_imem_ready),
        .i_imem_rdata    (i_imem_rdata),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .o_if_id_instr   (o_if_id_instr),
        .o_if_id_pc4     (o_if_id_pc4),
        .o_if_id_valid   (o_if_id_valid)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    assign i_imem_rdata = i_imem_ready ? memf(o_imem_addr) : 32'hBAD0_BAD0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc4;
    } vec_t;

    ent_t sb[$];
    logic model_valid;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, log scoreboard, then compare IF/ID at the next negedge.
    task automatic cyc(input logic s, input logic r, input logic b, input logic [31:0] t);
        logic exp_v;
        ent_t e;
        i_stall = s;
        i_imem_ready = r;
        i_branch_taken = b;
        i_branch_target = t;
        #1;
        if (b)
            sb.delete();
        else if (o_imem_req && r)
            sb.push_back('{instr: memf(o_imem_addr), pc4: o_imem_addr + 32'd4});
        exp_v = b ? 1'b0 : (s ? model_valid : (sb.size() > 0));
        @(posedge i_clk);
        @(negedge i_clk);
        check("sb_valid", {31'b0, o_if_id_valid}, {31'b0, exp_v});
        if (!b && !s && sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_instr", o_if_id_instr, e.instr);
            check("sb_pc4", o_if_id_pc4, e.pc4);
        end
        if (!exp_v) check("bubble_instr", o_if_id_instr, 32'h0);
        model_valid = exp_v;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        sb.delete();
        model_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'b0, o_imem_req}, 32'h0);
        check({tag, "_valid"}, {31'b0, o_if_id_valid}, 32'h0);
        check({tag, "_instr"}, o_if_id_instr, 32'h0);
        check({tag, "_pc4"},   o_if_id_pc4, 32'h0);
        check({tag, "_addr"},  o_imem_addr, 32'h1);
    endtask

    vec_t tbl[9];

    initial begin
        // Streaming from reset, then a 3-clk stall once @5 sits in IF/ID.
        tbl[0] = '{1'b0, 1'b1, 1'b1, 32'd1,  1'b0, 32'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'd5,  1'b1, 32'd5};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'd9,  1'b1, 32'd9};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'd13, 1'b1, 32'd9};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'd17, 1'b1, 32'd9};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'd17, 1'b1, 32'd9};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 32'd17, 1'b1, 32'd13};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 32'd21, 1'b1, 32'd17};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 32'd25, 1'b1, 32'd21};

        i_stall = 1'b0;
        i_imem_ready = 1'b0;
        i_branch_taken = 1'b0;
        i_branch_target = 32'h0;
        i_rst_n = 1'b0;
        sb.delete();
        model_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("reset");
        i_rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].stall, tbl[i].ready, 1'b0, 32'h0);
            check($sformatf("tbl%0d_req", i), {31'b0, o_imem_req}, {31'b0, tbl[i].exp_req});
            check($sformatf("tbl%0d_addr", i), o_imem_addr, tbl[i].exp_addr);
            check($sformatf("tbl%0d_valid", i), {31'b0, o_if_id_valid}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid)
                check($sformatf("tbl%0d_pc4", i), o_if_id_pc4, tbl[i].exp_pc4);
        end

        // Wait states at addr 9: two bubbles, then @9 bypassed.
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("ws_addr_start", o_imem_addr, 32'd9);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            check($sformatf("ws_addr_hold%0d", i), o_imem_addr, 32'd9);
            check($sformatf("ws_req%0d", i), {31'b0, o_imem_req}, 32'h1);
            check($sformatf("ws_bubble%0d", i), {31'b0, o_if_id_valid}, 32'h0);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("ws_pc4", o_if_id_pc4, 32'd13);
        check("ws_instr", o_if_id_instr, memf(32'd9));

        // Fill the queue under stall, then redirect to 37.
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        check("full_req", {31'b0, o_imem_req}, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 32'd37);
        check("br_valid", {31'b0, o_if_id_valid}, 32'h0);
        check("br_addr", o_imem_addr, 32'd37);
        check("br_req", {31'b0, o_imem_req}, 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("br_instr", o_if_id_instr, memf(32'd37));
        check("br_pc4", o_if_id_pc4, 32'd41);

        // Redirect coinciding with a returning word at 17: word is dropped.
        cyc(1'b0, 1'b1, 1'b1, 32'd17);
        check("drop_addr", o_imem_addr, 32'd17);
        cyc(1'b0, 1'b1, 1'b1, 32'd100);
        check("drop_valid", {31'b0, o_if_id_valid}, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("drop_pc4", o_if_id_pc4, 32'd104);
        check("drop_instr", o_if_id_instr, memf(32'd100));

        // Async reset while waiting on imem, then restart at 1.
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("wait_addr", o_imem_addr, 32'd104);
        i_imem_ready = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        sb.delete();
        model_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("restart_addr", o_imem_addr, 32'd1);
        check("restart_req", {31'b0, o_imem_req}, 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("restart_pc4", o_if_id_pc4, 32'd5);
        check("restart_instr", o_if_id_instr, memf(32'd1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
